uart_rx_decrypt_fsm: RTL and testbench

UART_RX_DECRYPT_FSM -- requirements
Module: uart_rx_decrypt_fsm

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_decrypt_fsm.sv | 96 +++++++++
 tb/tb_uart_rx_decrypt_fsm.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive-side decrypt path: FSM encoding,
// byte width and the ciphertext/keystream combine helper.
package uart_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    LOAD    = 3'd2,
    KS_WAIT = 3'd3,
    OUT     = 3'd4
  } state_t;

  // Stream-cipher decrypt: plaintext is ciphertext XOR keystream.
  function automatic logic [BYTE_W-1:0] decrypt_byte(input logic [BYTE_W-1:0] ct,
                                                     input logic [BYTE_W-1:0] ks);
    return ct ^ ks;
  endfunction

endpackage

// File: rtl/uart_rx_decrypt_fsm.sv
// Pops ciphertext bytes from a FIFO, XORs each with one Trivium keystream byte and
// hands the plaintext downstream. Optional macro UART_RX_DEC_BYPASS_EN adds bypass_i.
module uart_rx_decrypt_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_i,
  input  logic [BYTE_W-1:0] ciphertext_i,
  output logic              fifo_pop_o,
  input  logic              ks_ready_i,
  output logic              ks_req_o,
  input  logic              ks_valid_i,
  input  logic [BYTE_W-1:0] ks_byte_i,
`ifdef UART_RX_DEC_BYPASS_EN
  input  logic              bypass_i,
`endif
  output logic [BYTE_W-1:0] pt_data_o,
  output logic              pt_valid_o,
  input  logic              pt_ready_i,
  output logic [CNT_W-1:0]  byte_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [BYTE_W-1:0] ct_q;

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      fifo_pop_o <= 1'b0;
      ks_req_o   <= 1'b0;
      pt_valid_o <= 1'b0;
      pt_data_o  <= '0;
      ct_q       <= '0;
      byte_cnt_o <= '0;
    end else begin
      fifo_pop_o <= 1'b0;
      case (state)
        IDLE: begin
          // ks_ready_i only gates the start of a byte; later drops are ignored.
          if (!fifo_empty_i && ks_ready_i) begin
            fifo_pop_o <= 1'b1;
            state      <= POP;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          ct_q <= ciphertext_i;
`ifdef UART_RX_DEC_BYPASS_EN
          if (bypass_i) begin
            pt_data_o  <= ciphertext_i;
            pt_valid_o <= 1'b1;
            state      <= OUT;
          end else begin
            ks_req_o <= 1'b1;
            state    <= KS_WAIT;
          end
`else
          ks_req_o <= 1'b1;
          state    <= KS_WAIT;
`endif
        end
        KS_WAIT: begin
          if (ks_valid_i) begin
            ks_req_o   <= 1'b0;
            pt_data_o  <= decrypt_byte(ct_q, ks_byte_i);
            pt_valid_o <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (pt_ready_i) begin
            pt_valid_o <= 1'b0;
            state      <= IDLE;
            if (byte_cnt_o != CNT_MAX) begin
              byte_cnt_o <= byte_cnt_o + CNT_W'(1);
            end
          end
        end
        default: begin
          ks_req_o   <= 1'b0;
          pt_valid_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_decrypt_fsm.sv
// Self-checking bench for uart_rx_decrypt_fsm: directed scenarios plus randomized
// traffic compared every cycle against a timing/transaction reference model.
module tb_uart_rx_decrypt_fsm;

  logic        clk;
  logic        rst;
  logic        fifo_empty_i;
  logic [7:0]  ciphertext_i;
  logic        ks_ready_i;
  logic        ks_valid_i;
  logic [7:0]  ks_byte_i;
  logic        pt_ready_i;
`ifdef UART_RX_DEC_BYPASS_EN
  logic        bypass_i;
`endif
  logic        fifo_pop_o, ks_req_o, pt_valid_o;
  logic [7:0]  pt_data_o;
  logic [15:0] byte_cnt_o;
  logic        pop2, req2, valid2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  uart_rx_decrypt_fsm dut (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty_i), .ciphertext_i(ciphertext_i),
    .fifo_pop_o(fifo_pop_o), .ks_ready_i(ks_ready_i), .ks_req_o(ks_req_o),
    .ks_valid_i(ks_valid_i), .ks_byte_i(ks_byte_i),
`ifdef UART_RX_DEC_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .pt_data_o(pt_data_o), .pt_valid_o(pt_valid_o), .pt_ready_i(pt_ready_i),
    .byte_cnt_o(byte_cnt_o)
  );

  uart_rx_decrypt_fsm #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty_i), .ciphertext_i(ciphertext_i),
    .fifo_pop_o(pop2), .ks_ready_i(ks_ready_i), .ks_req_o(req2),
    .ks_valid_i(ks_valid_i), .ks_byte_i(ks_byte_i),
`ifdef UART_RX_DEC_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .pt_data_o(data2), .pt_valid_o(valid2), .pt_ready_i(pt_ready_i),
    .byte_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit rnd = 1'b0;
  bit cmp_en = 1'b0;
  logic [7:0] fifo_q[$];

  // Reference model: a byte job is timed from the edge that accepted it.
  bit         m_busy = 1'b0, m_ks_done = 1'b0, m_post_rst = 1'b0;
  bit         m_pop = 1'b0, m_req = 1'b0, m_valid = 1'b0;
  int         m_cyc = 0, m_start = 0, m_cnt = 0;
  logic [7:0] m_ct = 8'h00, m_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update();
    int age;
    m_cyc++;
    if (!rst) begin
      m_busy = 1'b0; m_pop = 1'b0; m_req = 1'b0; m_valid = 1'b0;
      m_data = 8'h00; m_cnt = 0; m_post_rst = 1'b1;
    end else begin
      if (!m_busy) begin
        if (!fifo_empty_i && ks_ready_i) begin
          m_busy = 1'b1; m_start = m_cyc; m_ks_done = 1'b0;
        end
      end else begin
        age = m_cyc - m_start;
        if (age == 2) begin
          m_ct = ciphertext_i;
`ifdef UART_RX_DEC_BYPASS_EN
          if (bypass_i) begin
            m_data = m_ct; m_ks_done = 1'b1; m_post_rst = 1'b0;
          end
`endif
        end else if (age >= 3 && !m_ks_done) begin
          if (ks_valid_i) begin
            m_data = m_ct ^ ks_byte_i; m_ks_done = 1'b1; m_post_rst = 1'b0;
          end
        end else if (m_ks_done && pt_ready_i) begin
          m_cnt++; m_busy = 1'b0;
        end
      end
      age = m_cyc - m_start;
      m_pop   = m_busy && (age == 0);
      m_req   = m_busy && (age >= 2) && !m_ks_done;
      m_valid = m_busy && m_ks_done;
    end
  endtask

  // One clock: model samples the same inputs as the DUT, then new inputs are driven.
  task automatic cyc();
    bit was_pop;
    @(posedge clk);
    was_pop = m_pop;
    model_update();
    #2;
    if (was_pop && fifo_q.size() > 0) ciphertext_i = fifo_q.pop_front();
    else ciphertext_i = 8'($urandom);
    if (rnd) begin
      ks_ready_i = ($urandom_range(0, 7) != 0);
      ks_valid_i = ($urandom_range(0, 2) == 0);
      ks_byte_i  = 8'($urandom);
      pt_ready_i = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 5) == 0) fifo_q.push_back(8'($urandom));
`ifdef UART_RX_DEC_BYPASS_EN
      bypass_i = ($urandom_range(0, 3) == 0);
`endif
    end
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty_i = 1'b0;
  endtask

  task automatic run_to_valid(input int limit, output int n, output int pops, output int reqs);
    n = 0; pops = 0; reqs = 0;
    while (n < limit && !pt_valid_o) begin
      cyc();
      n++;
      pops += int'(fifo_pop_o);
      reqs += int'(ks_req_o);
    end
    check("valid_timeout", 32'(pt_valid_o), 32'h1);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pop",    32'(fifo_pop_o), 32'(m_pop));
      check("req",    32'(ks_req_o),   32'(m_req));
      check("valid",  32'(pt_valid_o), 32'(m_valid));
      check("cnt16",  32'(byte_cnt_o), 32'(sat(m_cnt, 65535)));
      check("pop2",   32'(pop2),       32'(m_pop));
      check("req2",   32'(req2),       32'(m_req));
      check("valid2", 32'(valid2),     32'(m_valid));
      check("cnt2",   32'(cnt2),       32'(sat(m_cnt, 3)));
      if (m_valid || m_post_rst) begin
        check("data",  32'(pt_data_o), 32'(m_data));
        check("data2", 32'(data2),     32'(m_data));
      end
    end
  end

  initial begin
    int n, pops, reqs, hs, ks, reqhi;
    rst = 1'b0; fifo_empty_i = 1'b1; ciphertext_i = 8'h00; ks_ready_i = 1'b1;
    ks_valid_i = 1'b0; ks_byte_i = 8'h00; pt_ready_i = 1'b1;
`ifdef UART_RX_DEC_BYPASS_EN
    bypass_i = 1'b0;
`endif
    cyc();
    cmp_en = 1'b1;
    cyc();
    check("rst_pop",   32'(fifo_pop_o), 32'h0);
    check("rst_req",   32'(ks_req_o),   32'h0);
    check("rst_valid", 32'(pt_valid_o), 32'h0);
    check("rst_data",  32'(pt_data_o),  32'h0);
    check("rst_cnt",   32'(byte_cnt_o), 32'h0);
    rst = 1'b1;

    // Scenario 1: 0xA5 ^ 0x3C, immediate keystream, 4-cycle latency.
    ks_valid_i = 1'b1; ks_byte_i = 8'h3C;
    push(8'hA5);
    run_to_valid(20, n, pops, reqs);
    check("s1_latency", 32'(n), 32'd4);
    check("s1_data", 32'(pt_data_o), 32'h99);
    check("s1_pops", 32'(pops), 32'd1);
    cyc();
    check("s1_cnt", 32'(byte_cnt_o), 32'd1);

    // Scenario 2: keystream not ready holds the block in IDLE.
    ks_ready_i = 1'b0;
    push(8'h11);
    pops = 0; reqs = 0;
    repeat (10) begin
      cyc();
      pops += int'(fifo_pop_o);
      reqs += int'(ks_req_o);
    end
    check("s2_no_pop", 32'(pops), 32'd0);
    check("s2_no_req", 32'(reqs), 32'd0);
    ks_ready_i = 1'b1;
    cyc();
    check("s2_pop_after_ready", 32'(fifo_pop_o), 32'h1);
    run_to_valid(20, n, pops, reqs);
    check("s2_data", 32'(pt_data_o), 32'h2D);
    cyc();
    check("s2_cnt", 32'(byte_cnt_o), 32'd2);

    // Scenario 3: downstream stall keeps the result stable.
    pt_ready_i = 1'b0; ks_byte_i = 8'h0F;
    push(8'h77);
    run_to_valid(20, n, pops, reqs);
    pops = 0;
    repeat (6) begin
      cyc();
      pops += int'(fifo_pop_o);
      check("s3_valid", 32'(pt_valid_o), 32'h1);
      check("s3_data",  32'(pt_data_o),  32'h78);
      check("s3_cnt",   32'(byte_cnt_o), 32'd2);
    end
    check("s3_no_pop", 32'(pops), 32'd0);
    pt_ready_i = 1'b1;
    cyc();
    check("s3_cnt_after", 32'(byte_cnt_o), 32'd3);

    // Scenario 4: keystream arrives on the sixth request cycle.
    ks_valid_i = 1'b0; ks_byte_i = 8'hFF;
    push(8'h3C);
    n = 0; reqhi = 0;
    while (n < 40 && !pt_valid_o) begin
      cyc();
      n++;
      if (ks_req_o) reqhi++;
      if (reqhi == 6) ks_valid_i = 1'b1;
    end
    check("s4_req_cycles", 32'(reqhi), 32'd6);
    check("s4_data", 32'(pt_data_o), 32'hC3);
    cyc();
    ks_byte_i = 8'h10;
    push(8'h01); push(8'h02); push(8'h03);
    pops = 0; ks = 0; hs = 0;
    repeat (20) begin
      cyc();
      pops += int'(fifo_pop_o);
      ks   += int'(ks_req_o && ks_valid_i);
      hs   += int'(pt_valid_o && pt_ready_i);
    end
    check("s4_pops", 32'(pops), 32'd3);
    check("s4_ks",   32'(ks),   32'd3);
    check("s4_hs",   32'(hs),   32'd3);
    check("s4_cnt16", 32'(byte_cnt_o), 32'd7);
    check("s4_cnt2",  32'(cnt2),       32'd3);

    // Scenario 5: reset while waiting for keystream.
    ks_valid_i = 1'b0;
    push(8'h42);
    n = 0;
    while (n < 20 && !ks_req_o) begin
      cyc();
      n++;
    end
    check("s5_in_ks_wait", 32'(ks_req_o), 32'h1);
    rst = 1'b0;
    cyc();
    check("s5_pop",   32'(fifo_pop_o), 32'h0);
    check("s5_req",   32'(ks_req_o),   32'h0);
    check("s5_valid", 32'(pt_valid_o), 32'h0);
    check("s5_data",  32'(pt_data_o),  32'h0);
    check("s5_cnt",   32'(byte_cnt_o), 32'h0);
    rst = 1'b1;
    cyc();
    check("s5_post_pop", 32'(fifo_pop_o), 32'h0);
    check("s5_post_req", 32'(ks_req_o),   32'h0);
    ks_valid_i = 1'b1;

`ifdef UART_RX_DEC_BYPASS_EN
    // Scenario 6: bypass passes ciphertext through without keystream.
    bypass_i = 1'b1; ks_valid_i = 1'b0;
    push(8'h5A);
    run_to_valid(20, n, pops, reqs);
    check("s6_data", 32'(pt_data_o), 32'h5A);
    check("s6_no_req", 32'(reqs), 32'd0);
    cyc();
    bypass_i = 1'b0; ks_valid_i = 1'b1;
`endif

    rnd = 1'b1;
    repeat (4000) cyc();
    rnd = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
